// File: rtl/dma_bench_stats.sv
// Run-time, per-iteration latency and op-count statistics for the looped DMA
// benchmark; results are held for host readout until the next run or a clear.
module dma_bench_stats #(
    parameter int unsigned C_NITERATIONS = 8,
    parameter int unsigned C_LAT_WIDTH   = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   ENGINE_VALID,
    input  logic                   OP_DONE,
    input  logic                   CLEAR,
    output logic [63:0]            TOTAL_CYCLES,
    output logic [C_LAT_WIDTH-1:0] OP_COUNT,
    output logic [C_LAT_WIDTH-1:0] MIN_LATENCY,
    output logic [C_LAT_WIDTH-1:0] MAX_LATENCY,
    output logic                   BUSY,
    output logic                   RESULT_VALID,
    output logic                   COUNT_MISMATCH
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [C_LAT_WIDTH-1:0] NITER = C_LAT_WIDTH'(C_NITERATIONS);

    state_t                 state_q, state_d;
    logic [63:0]            total_q, total_d;
    logic [C_LAT_WIDTH-1:0] count_q, count_d;
    logic [C_LAT_WIDTH-1:0] min_q,   min_d;
    logic [C_LAT_WIDTH-1:0] max_q,   max_d;
    logic [C_LAT_WIDTH-1:0] lat_q,   lat_d;

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        count_d = count_q;
        min_d   = min_q;
        max_d   = max_q;
        lat_d   = lat_q;

        if (CLEAR) begin
            state_d = S_IDLE;
            total_d = '0;
            count_d = '0;
            min_d   = '1;
            max_d   = '0;
            lat_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (ENGINE_VALID) begin
                        state_d = S_RUN;
                        total_d = '0;
                        count_d = '0;
                        min_d   = '1;
                        max_d   = '0;
                        lat_d   = C_LAT_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    if (total_q != '1)
                        total_d = total_q + 64'd1;
                    // The strobe of the last RUN cycle still counts, even as valid drops.
                    if (OP_DONE) begin
                        if (lat_q < min_q)
                            min_d = lat_q;
                        if (lat_q > max_q)
                            max_d = lat_q;
                        if (count_q != '1)
                            count_d = count_q + C_LAT_WIDTH'(1);
                        lat_d = C_LAT_WIDTH'(1);
                    end else if (lat_q != '1) begin
                        lat_d = lat_q + C_LAT_WIDTH'(1);
                    end
                    if (!ENGINE_VALID)
                        state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            total_q <= '0;
            count_q <= '0;
            min_q   <= '1;
            max_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            count_q <= count_d;
            min_q   <= min_d;
            max_q   <= max_d;
            lat_q   <= lat_d;
        end
    end

    // Min register idles at all ones; hide that sentinel until a sample exists.
    assign TOTAL_CYCLES   = total_q;
    assign OP_COUNT       = count_q;
    assign MIN_LATENCY    = (count_q == '0) ? '0 : min_q;
    assign MAX_LATENCY    = max_q;
    assign BUSY           = (state_q == S_RUN);
    assign RESULT_VALID   = (state_q == S_DONE);
    assign COUNT_MISMATCH = (state_q == S_DONE) && (count_q != NITER);

endmodule

// File: tb/tb_dma_bench_stats.sv
// Directed bench for dma_bench_stats: a run-level model (cycle count plus list
// of iteration latencies) checked every cycle, plus literal result pins.
module tb_dma_bench_stats;

    localparam int unsigned NITER = 4;
    localparam int unsigned LW    = 32;

    logic          CLK;
    logic          RST_N;
    logic          ENGINE_VALID;
    logic          OP_DONE;
    logic          CLEAR;
    logic [63:0]   TOTAL_CYCLES;
    logic [LW-1:0] OP_COUNT;
    logic [LW-1:0] MIN_LATENCY;
    logic [LW-1:0] MAX_LATENCY;
    logic          BUSY;
    logic          RESULT_VALID;
    logic          COUNT_MISMATCH;

    int checks   = 0;
    int failures = 0;

    dma_bench_stats #(
        .C_NITERATIONS(NITER),
        .C_LAT_WIDTH  (LW)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .ENGINE_VALID  (ENGINE_VALID),
        .OP_DONE       (OP_DONE),
        .CLEAR         (CLEAR),
        .TOTAL_CYCLES  (TOTAL_CYCLES),
        .OP_COUNT      (OP_COUNT),
        .MIN_LATENCY   (MIN_LATENCY),
        .MAX_LATENCY   (MAX_LATENCY),
        .BUSY          (BUSY),
        .RESULT_VALID  (RESULT_VALID),
        .COUNT_MISMATCH(COUNT_MISMATCH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level model: phase, RUN cycles elapsed, and the list of latencies seen.
    int          m_phase = 0;   // 0 idle, 1 run, 2 done
    longint      m_total = 0;
    int unsigned m_cur   = 0;
    int unsigned m_lats[$];
    bit          m_armed = 0;

    function automatic longint m_min();
        longint r;
        if (m_lats.size() == 0) return 0;
        r = m_lats[0];
        foreach (m_lats[i]) if (m_lats[i] < r) r = m_lats[i];
        return r;
    endfunction

    function automatic longint m_max();
        longint r = 0;
        foreach (m_lats[i]) if (m_lats[i] > r) r = m_lats[i];
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge CLK);
            if (!RST_N || CLEAR) begin
                m_phase = 0;
                m_total = 0;
                m_cur   = 0;
                m_lats.delete();
            end else if (m_phase == 1) begin
                m_total++;
                m_cur++;
                if (OP_DONE) begin
                    m_lats.push_back(m_cur);
                    m_cur = 0;
                end
                if (!ENGINE_VALID) m_phase = 2;
            end else if (ENGINE_VALID) begin
                m_phase = 1;
                m_total = 0;
                m_cur   = 0;
                m_lats.delete();
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N && m_armed) begin
                check("model_total", TOTAL_CYCLES, 64'(m_total));
                check("model_count", 64'(OP_COUNT), 64'(m_lats.size()));
                check("model_min",   64'(MIN_LATENCY), 64'(m_min()));
                check("model_max",   64'(MAX_LATENCY), 64'(m_max()));
                check("model_busy",  64'(BUSY), 64'(m_phase == 1));
                check("model_valid", 64'(RESULT_VALID), 64'(m_phase == 2));
                check("model_mism",  64'(COUNT_MISMATCH),
                      64'((m_phase == 2) && (m_lats.size() != NITER)));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_total"}, TOTAL_CYCLES, 64'd0);
        check({tag, "_count"}, 64'(OP_COUNT), 64'd0);
        check({tag, "_min"},   64'(MIN_LATENCY), 64'd0);
        check({tag, "_max"},   64'(MAX_LATENCY), 64'd0);
        check({tag, "_busy"},  64'(BUSY), 64'd0);
        check({tag, "_valid"}, 64'(RESULT_VALID), 64'd0);
        check({tag, "_mism"},  64'(COUNT_MISMATCH), 64'd0);
    endtask

    // Starts from IDLE/DONE at a falling edge. ENGINE_VALID stays high for RUN
    // cycles 1..len and is seen low in RUN cycle len+1; OP_DONE in RUN cycle k
    // when mask[k-1]. Returns at the falling edge of the first DONE cycle.
    task automatic run_pattern(input int len, input logic [63:0] mask);
        ENGINE_VALID = 1'b1;
        OP_DONE      = 1'b0;
        @(negedge CLK);
        for (int k = 1; k <= len + 1; k++) begin
            ENGINE_VALID = (k <= len);
            OP_DONE      = mask[k-1];
            @(negedge CLK);
        end
        ENGINE_VALID = 1'b0;
        OP_DONE      = 1'b0;
    endtask

    initial begin
        RST_N        = 1'b0;
        ENGINE_VALID = 1'b0;
        OP_DONE      = 1'b0;
        CLEAR        = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST_N   = 1'b1;
        m_armed = 1'b1;
        @(negedge CLK);

        // Four evenly spaced iterations, count matches.
        run_pattern(40, (64'd1 << 9) | (64'd1 << 19) | (64'd1 << 29) | (64'd1 << 39));
        check("t1_total", TOTAL_CYCLES, 64'd41);
        check("t1_count", 64'(OP_COUNT), 64'd4);
        check("t1_min",   64'(MIN_LATENCY), 64'd10);
        check("t1_max",   64'(MAX_LATENCY), 64'd10);
        check("t1_valid", 64'(RESULT_VALID), 64'd1);
        check("t1_mism",  64'(COUNT_MISMATCH), 64'd0);

        // Back-to-back from DONE: strobes at RUN cycles 1, 2, 7.
        run_pattern(9, (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 6));
        check("t2_total", TOTAL_CYCLES, 64'd10);
        check("t2_count", 64'(OP_COUNT), 64'd3);
        check("t2_min",   64'(MIN_LATENCY), 64'd1);
        check("t2_max",   64'(MAX_LATENCY), 64'd5);
        check("t2_mism",  64'(COUNT_MISMATCH), 64'd1);

        // No strobes at all.
        run_pattern(6, 64'd0);
        check("t3_count", 64'(OP_COUNT), 64'd0);
        check("t3_min",   64'(MIN_LATENCY), 64'd0);
        check("t3_max",   64'(MAX_LATENCY), 64'd0);
        check("t3_mism",  64'(COUNT_MISMATCH), 64'd1);

        // Strobe coincident with the valid-low sample.
        run_pattern(5, 64'd1 << 5);
        check("t4_total", TOTAL_CYCLES, 64'd6);
        check("t4_count", 64'(OP_COUNT), 64'd1);
        check("t4_min",   64'(MIN_LATENCY), 64'd6);
        check("t4_max",   64'(MAX_LATENCY), 64'd6);
        check("t4_valid", 64'(RESULT_VALID), 64'd1);

        // Strobe in DONE is ignored.
        OP_DONE = 1'b1;
        @(negedge CLK);
        OP_DONE = 1'b0;
        check("t5_count", 64'(OP_COUNT), 64'd1);

        // New run, then CLEAR together with OP_DONE and ENGINE_VALID mid-run.
        ENGINE_VALID = 1'b1;
        @(negedge CLK);
        check("t6_busy",  64'(BUSY), 64'd1);
        check("t6_count", 64'(OP_COUNT), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            OP_DONE = (k == 2);
            @(negedge CLK);
        end
        CLEAR   = 1'b1;
        OP_DONE = 1'b1;
        @(negedge CLK);
        CLEAR        = 1'b0;
        OP_DONE      = 1'b0;
        ENGINE_VALID = 1'b0;
        check_all_zero("clear");
        OP_DONE = 1'b1;
        @(negedge CLK);
        OP_DONE = 1'b0;
        check_all_zero("idle_op");

        // Asynchronous reset mid-run, valid held high through release.
        ENGINE_VALID = 1'b1;
        @(negedge CLK);
        for (int k = 1; k <= 3; k++) begin
            OP_DONE = (k == 2);
            @(negedge CLK);
        end
        OP_DONE = 1'b0;
        #2 RST_N = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("t7_busy",   64'(BUSY), 64'd1);
        check("t7_total0", TOTAL_CYCLES, 64'd0);
        @(negedge CLK);
        check("t7_total1", TOTAL_CYCLES, 64'd1);
        ENGINE_VALID = 1'b0;
        @(negedge CLK);
        check("t7_total2", TOTAL_CYCLES, 64'd2);
        check("t7_valid",  64'(RESULT_VALID), 64'd1);
        check("t7_mism",   64'(COUNT_MISMATCH), 64'd1);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_bench_stats.md
# dma_bench_stats

Cycle-accurate statistics collector placed directly downstream of the descriptor-faking benchmark stage. It observes the engine-valid level and the per-iteration end-of-operation strobe driven into the DMA engine. It measures:
- total run time,
- per-iteration latency (min/max),
- completed-operation count.

Results are held in registers for host readout over the BAR register file. It lets software turn a hardware-looped DMA benchmark into throughput and latency figures without per-transfer host timestamps.

## Interface
Parameters:
- C_NITERATIONS, 8, expected operations per run; used only for the mismatch flag
- C_LAT_WIDTH, 32, width of latency/min/max/count registers (16..32)

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- ENGINE_VALID  in  1  faked engine-valid level; high for the whole benchmark run
- OP_DONE  in  1  single-cycle end-of-operation strobe, one per iteration (control byte bit 3 from the engine)
- CLEAR  in  1  host clear pulse; discards results, returns to IDLE
- TOTAL_CYCLES  out  64  cycles spent in RUN for the last/current run
- OP_COUNT  out  C_LAT_WIDTH  OP_DONE strobes seen in the run
- MIN_LATENCY  out  C_LAT_WIDTH  smallest iteration latency; 0 while OP_COUNT==0
- MAX_LATENCY  out  C_LAT_WIDTH  largest iteration latency
- BUSY  out  1  high in RUN
- RESULT_VALID  out  1  high in DONE
- COUNT_MISMATCH  out  1  high in DONE when OP_COUNT != C_NITERATIONS

## Operation
- Three states: IDLE, RUN, DONE.
- Reset value of every output is 0. Internal min register resets to all ones. Reset mid-run aborts immediately with no partial results kept.
- IDLE:
  - ENGINE_VALID sampled high → RUN.
  - On the same edge: total=0, count=0, max=0, min=all ones, lat=1.
- RUN, every cycle:
  - total += 1, saturating at 2^64-1.
  - If OP_DONE: latency sample = lat. min = min(min, lat). max = max(max, lat). count += 1 (saturating). lat = 1 next cycle.
  - Else lat += 1, saturating at all ones.
  - ENGINE_VALID sampled low → DONE. That cycle's total increment and any coincident OP_DONE are still applied.
- DONE:
  - All results frozen.
  - ENGINE_VALID high → RUN with the same clearing as from IDLE (back-to-back runs).
- CLEAR in any state: next state IDLE, all result registers back to reset values. CLEAR takes priority over ENGINE_VALID and OP_DONE in the same cycle.
- OP_DONE while in IDLE or DONE is ignored.
- MIN_LATENCY output is forced to 0 while count==0, so the all-ones sentinel is never visible.
- COUNT_MISMATCH = RESULT_VALID && (OP_COUNT != C_NITERATIONS).

## Timing
- All outputs are registered state or a simple function of it. Values update one cycle after the sampling edge.
- BUSY rises the cycle after ENGINE_VALID is first seen high. It falls the cycle after ENGINE_VALID is seen low.
- Latency definition: number of RUN cycles from the iteration's first cycle up to and including its OP_DONE cycle.
  - OP_DONE in the first RUN cycle gives latency 1.
  - OP_DONE strobes on consecutive cycles give latency 1 each.
- TOTAL_CYCLES equals the number of cycles BUSY was high.
- Every statistic of a run is final and stable in the first cycle RESULT_VALID is high.

## Test plan
- ENGINE_VALID high for 40 cycles, OP_DONE at RUN cycles 10, 20, 30, 40, C_NITERATIONS=4 → TOTAL_CYCLES=41, OP_COUNT=4, MIN=MAX=10, COUNT_MISMATCH=0, RESULT_VALID=1.
- OP_DONE at RUN cycles 1, 2, 7, then valid drops → MIN=1, MAX=5, OP_COUNT=3, COUNT_MISMATCH=1 with C_NITERATIONS=8.
- Run with no OP_DONE → OP_COUNT=0, MIN_LATENCY=0, MAX_LATENCY=0, COUNT_MISMATCH=1.
- OP_DONE coincident with the ENGINE_VALID-low sample → strobe counted, latency included, state goes to DONE.
- In DONE, raise ENGINE_VALID again → new run starts and prior results are cleared. Then CLEAR asserted together with OP_DONE mid-run → IDLE, all outputs 0, strobe not counted.
- Assert RST_N low mid-run → all outputs 0 asynchronously. After release, ENGINE_VALID still high → new RUN starts with TOTAL_CYCLES counting from 1.
